core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 160 ++++++++++++++++
 tb/tb_core_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH..WB instruction sequencer with HALT; one stage per unstalled cycle, strobes decoded from registered state.
// Backpressure: i_stall freezes state, wait counter and flags, and masks all strobes; RESET/HALT ignore it.
module core_sequencer #(
   parameter int FETCH_LAT = 1,
   parameter int MEM_LAT   = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_stall,
   input  logic             i_is_mem,
   input  logic             i_regwe,
   input  logic             i_branch,
   input  logic             i_halt,
   input  logic             i_resume,
   output logic             o_enfetch,
   output logic             o_endec,
   output logic             o_enrgrd,
   output logic             o_enalu,
   output logic             o_enmem,
   output logic             o_update,
   output logic             o_regwr,
   output logic [1:0]       o_pc_op,
   output logic [2:0]       o_state,
   output logic [CNT_W-1:0] o_retired,
   output logic             o_halted
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_REGRD  = 3'd3,
      S_ALU    = 3'd4,
      S_MEM    = 3'd5,
      S_WB     = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [2:0] FETCH_RLD = 3'(FETCH_LAT - 1);
   localparam logic [2:0] MEM_RLD   = 3'(MEM_LAT - 1);

   state_t           state_q, state_d;
   logic [2:0]       wcnt_q, wcnt_d;
   logic             mem_q, mem_d;
   logic             regwe_q, regwe_d;
   logic             br_q, br_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   logic             released_q;
   logic             run;

   assign run = ~i_stall;

   // released_q keeps RESET for one full cycle after rst deasserts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_RESET;
         wcnt_q     <= '0;
         mem_q      <= 1'b0;
         regwe_q    <= 1'b0;
         br_q       <= 1'b0;
         ret_q      <= '0;
         released_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         mem_q      <= mem_d;
         regwe_q    <= regwe_d;
         br_q       <= br_d;
         ret_q      <= ret_d;
         released_q <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      mem_d     = mem_q;
      regwe_d   = regwe_q;
      br_d      = br_q;
      ret_d     = ret_q;
      o_enfetch = 1'b0;
      o_endec   = 1'b0;
      o_enrgrd  = 1'b0;
      o_enalu   = 1'b0;
      o_enmem   = 1'b0;
      o_update  = 1'b0;
      o_regwr   = 1'b0;
      o_pc_op   = 2'b00;
      case (state_q)
         S_RESET: begin
            o_pc_op = 2'b11;
            if (released_q) begin
               state_d = S_FETCH;
               wcnt_d  = FETCH_RLD;
               mem_d   = 1'b0;
               regwe_d = 1'b0;
               br_d    = 1'b0;
            end
         end
         S_FETCH: if (run) begin
            o_enfetch = 1'b1;
            if (wcnt_q == 3'd0) state_d = S_DECODE;
            else                wcnt_d  = wcnt_q - 3'd1;
         end
         S_DECODE: if (run) begin
            o_endec = 1'b1;
            mem_d   = i_is_mem;
            regwe_d = i_regwe;
            state_d = S_REGRD;
         end
         S_REGRD: if (run) begin
            o_enrgrd = 1'b1;
            state_d  = S_ALU;
         end
         S_ALU: if (run) begin
            o_enalu = 1'b1;
            br_d    = i_branch;
            if (mem_q) begin
               state_d = S_MEM;
               wcnt_d  = MEM_RLD;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: if (run) begin
            o_enmem = 1'b1;
            if (wcnt_q == 3'd0) state_d = S_WB;
            else                wcnt_d  = wcnt_q - 3'd1;
         end
         S_WB: if (run) begin
            o_update = 1'b1;
            o_regwr  = regwe_q;
            o_pc_op  = br_q ? 2'b10 : 2'b01;
            ret_d    = ret_q + 1'b1;
            if (i_halt) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;
               wcnt_d  = FETCH_RLD;
               mem_d   = 1'b0;
               regwe_d = 1'b0;
               br_d    = 1'b0;
            end
         end
         S_HALT: if (i_resume) begin
            state_d = S_FETCH;
            wcnt_d  = FETCH_RLD;
            mem_d   = 1'b0;
            regwe_d = 1'b0;
            br_d    = 1'b0;
         end
      endcase
   end

   assign o_state   = state_q;
   assign o_retired = ret_q;
   assign o_halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: random stall/flag stimulus against a per-instruction stage-list model.
module tb_core_sequencer;
   localparam int FL = 2;
   localparam int ML = 3;
   localparam int CW = 4;
   localparam int ST_RESET = 0, ST_FETCH = 1, ST_DECODE = 2, ST_REGRD = 3,
                  ST_ALU = 4, ST_MEM = 5, ST_WB = 6, ST_HALT = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          i_stall = 1'b0, i_is_mem = 1'b0, i_regwe = 1'b0, i_branch = 1'b0;
   logic          i_halt = 1'b0, i_resume = 1'b0;
   logic          o_enfetch, o_endec, o_enrgrd, o_enalu, o_enmem, o_update, o_regwr;
   logic [1:0]    o_pc_op;
   logic [2:0]    o_state;
   logic [CW-1:0] o_retired;
   logic          o_halted;

   core_sequencer #(.FETCH_LAT(FL), .MEM_LAT(ML), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .i_stall(i_stall), .i_is_mem(i_is_mem), .i_regwe(i_regwe),
      .i_branch(i_branch), .i_halt(i_halt), .i_resume(i_resume),
      .o_enfetch(o_enfetch), .o_endec(o_endec), .o_enrgrd(o_enrgrd), .o_enalu(o_enalu),
      .o_enmem(o_enmem), .o_update(o_update), .o_regwr(o_regwr), .o_pc_op(o_pc_op),
      .o_state(o_state), .o_retired(o_retired), .o_halted(o_halted)
   );

   int vectors = 0;
   int miscompares = 0;

   // Model: current expected stage plus the remaining stage list of the instruction
   int exp_st;
   int plan[$];
   int m_ret;
   int n_ret;
   bit cur_mem, cur_regwe, cur_br, cur_halt;
   int stall_pct = 0, halt_pct = 0, resume_pct = 30, mem_pct = 50;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [12:0] expect_outs(input int st, input bit stall,
                                               input bit regwe, input bit br);
      logic [5:0] strb;
      logic       regwr;
      logic [1:0] pc;
      strb  = 6'b0;
      regwr = 1'b0;
      pc    = 2'b00;
      if (st == ST_RESET) pc = 2'b11;
      else if (!(stall && st >= ST_FETCH && st <= ST_WB)) begin
         case (st)
            ST_FETCH:  strb = 6'b100000;
            ST_DECODE: strb = 6'b010000;
            ST_REGRD:  strb = 6'b001000;
            ST_ALU:    strb = 6'b000100;
            ST_MEM:    strb = 6'b000010;
            ST_WB: begin
               strb  = 6'b000001;
               regwr = regwe;
               pc    = br ? 2'b10 : 2'b01;
            end
            default: ;
         endcase
      end
      return {strb, regwr, pc, 3'(st), (st == ST_HALT)};
   endfunction

   function automatic void new_instr();
      cur_mem   = ($urandom_range(0, 99) < mem_pct);
      cur_regwe = 1'($urandom_range(0, 1));
      cur_br    = 1'($urandom_range(0, 1));
      cur_halt  = ($urandom_range(0, 99) < halt_pct);
      plan.delete();
      for (int i = 1; i < FL; i++) plan.push_back(ST_FETCH);
      plan.push_back(ST_DECODE);
      plan.push_back(ST_REGRD);
      plan.push_back(ST_ALU);
      if (cur_mem) for (int i = 0; i < ML; i++) plan.push_back(ST_MEM);
      plan.push_back(ST_WB);
      exp_st = ST_FETCH;
   endfunction

   function automatic void model_edge();
      if (!rst) return;
      if (exp_st >= ST_FETCH && exp_st <= ST_WB && i_stall) return;
      if (exp_st == ST_WB) begin
         m_ret = (m_ret + 1) % (1 << CW);
         n_ret++;
         if (cur_halt) exp_st = ST_HALT;
         else          new_instr();
      end else if (exp_st == ST_HALT) begin
         if (i_resume) new_instr();
      end else if (plan.size() > 0) begin
         exp_st = plan.pop_front();
      end else begin
         new_instr();
      end
   endfunction

   // One clock: drive at posedge+1, compare at negedge, advance model at posedge
   task automatic cyc(input logic rst_v, input int stall_mode);
      rst = rst_v;
      if (!rst_v) begin
         exp_st = ST_RESET;
         plan.delete();
         plan.push_back(ST_RESET);
         m_ret = 0;
         n_ret = 0;
      end
      i_stall  = (stall_mode < 0) ? ($urandom_range(0, 99) < stall_pct) : (stall_mode != 0);
      i_is_mem = (exp_st == ST_DECODE) ? cur_mem   : 1'($urandom_range(0, 1));
      i_regwe  = (exp_st == ST_DECODE) ? cur_regwe : 1'($urandom_range(0, 1));
      i_branch = (exp_st == ST_ALU)    ? cur_br    : 1'($urandom_range(0, 1));
      i_halt   = (exp_st == ST_WB)     ? cur_halt  : 1'($urandom_range(0, 1));
      i_resume = (exp_st == ST_HALT)   ? ($urandom_range(0, 99) < resume_pct)
                                       : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("outputs", 16'({o_enfetch, o_endec, o_enrgrd, o_enalu, o_enmem, o_update,
                            o_regwr, o_pc_op, o_state, o_halted}),
            16'(expect_outs(exp_st, i_stall, cur_regwe, cur_br)));
      check("retired", 16'(o_retired), 16'(m_ret));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic run_until(input int st, input int budget, input string tag);
      int n;
      n = 0;
      while (exp_st != st && n < budget) begin
         cyc(1'b1, -1);
         n++;
      end
      vectors++;
      assert (exp_st == st) else begin
         miscompares++;
         $error("FAIL %s: stage %0d not reached in %0d cycles (at %0d)", tag, st, budget, exp_st);
      end
   endtask

   initial begin
      exp_st = ST_RESET;
      plan.push_back(ST_RESET);
      m_ret = 0;
      n_ret = 0;
      #2 rst = 1'b0;

      // reset state, stall ignored in RESET, then two cycles to FETCH
      cyc(1'b0, 0);
      cyc(1'b0, 1);
      cyc(1'b1, 1);
      cyc(1'b1, 0);

      // unstalled instructions
      run_until(ST_WB, 40, "first_wb");
      repeat (30) cyc(1'b1, 0);

      // random stalls, halts and resumes
      stall_pct  = 25;
      halt_pct   = 15;
      resume_pct = 30;
      repeat (600) cyc(1'b1, -1);

      // 3-cycle stall in the middle of FETCH
      stall_pct = 0;
      halt_pct  = 0;
      run_until(ST_WB, 200, "pre_fetch_stall");
      cyc(1'b1, 0);
      cyc(1'b1, 0);
      repeat (3) cyc(1'b1, 1);
      run_until(ST_WB, 40, "post_fetch_stall");

      // HALT held for 10 cycles, then a resume pulse
      halt_pct   = 100;
      resume_pct = 0;
      stall_pct  = 30;
      run_until(ST_HALT, 200, "enter_halt");
      repeat (10) cyc(1'b1, -1);
      resume_pct = 100;
      halt_pct   = 0;
      cyc(1'b1, 1);
      resume_pct = 30;
      repeat (20) cyc(1'b1, -1);

      // counter wrap: 17 instructions from reset
      cyc(1'b0, -1);
      cyc(1'b0, -1);
      cyc(1'b1, -1);
      begin
         int n;
         n = 0;
         while (n_ret < 17 && n < 2000) begin
            cyc(1'b1, -1);
            n++;
         end
      end
      check("wrap17", 16'(o_retired), 16'd1);

      // reset during MEM aborts the instruction
      mem_pct   = 100;
      stall_pct = 0;
      run_until(ST_MEM, 200, "reach_mem");
      cyc(1'b1, 0);
      cyc(1'b0, 0);
      check("abort_retired", 16'(o_retired), 16'd0);
      cyc(1'b0, -1);
      cyc(1'b1, -1);
      mem_pct   = 50;
      stall_pct = 20;
      repeat (60) cyc(1'b1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
